jk_counter_sequencer: RTL and testbench

Controller FSM that drives a bank of `WIDTH` external JK flip-flops as a loadable, bidirectional synchronous counter. It presets the bank, counts until the bank reaches a programmed target, then stops and pulses `done`. All `j`/`k` vectors for the bank are generated here, and the bank's `q` outputs are fed back as inputs. It sits between the user-facing command logic and the JK flip-flop bank of the synchronous-counter datapath.

---
 rtl/jk_counter_sequencer.sv | 111 +++++++++++
 tb/tb_jk_counter_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_counter_sequencer.sv
// rtl/jk_counter_sequencer.sv - FSM driving an external JK flip-flop bank as a loadable up/down counter.
// Define JK_SEQ_ABORT_EN to add the abort input.
module jk_counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] target,
  input  logic             pause,
`ifdef JK_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             ff_reset,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic             dir_r;
  logic [WIDTH-1:0] load_r;
  logic [WIDTH-1:0] target_r;
  logic             abort_c;
  logic             at_target;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] tog;

`ifdef JK_SEQ_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  assign ff_reset  = reset;
  assign at_target = (q == target_r);

  // A stage toggles when every lower stage is 1 (up) or 0 (down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_tog
    assign up_t[i] = &q[i-1:0];
    assign dn_t[i] = &(~q[i-1:0]);
  end
  assign tog = dir_r ? up_t : dn_t;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dir_r    <= 1'b0;
      load_r   <= '0;
      target_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dir_r    <= dir;
            load_r   <= load_val;
            target_r <= target;
            state    <= LOAD;
          end
        end
        LOAD: state <= abort_c ? IDLE : RUN;
        RUN: begin
          if (abort_c)        state <= IDLE;
          else if (at_target) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    j    = '0;
    k    = '0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      LOAD: begin
        busy = 1'b1;
        if (!abort_c) begin
          j = load_r;
          k = ~load_r;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!abort_c && !at_target && !pause) begin
          j = tog;
          k = tog;
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jk_counter_sequencer.sv
// tb/tb_jk_counter_sequencer.sv - randomized bench with a JK bank model and arithmetic counter reference.
module tb_jk_counter_sequencer;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] target = '0;
  logic         pause = 1'b0;
`ifdef JK_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic [W-1:0] q;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         ff_reset;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jk_counter_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir),
    .load_val(load_val), .target(target), .pause(pause),
`ifdef JK_SEQ_ABORT_EN
    .abort(abort),
`endif
    .q(q), .j(j), .k(k), .ff_reset(ff_reset), .busy(busy), .done(done)
  );

  // External JK flip-flop bank: 00 hold, 01 clear, 10 set, 11 toggle.
  always @(posedge clk) begin
    if (ff_reset) q <= '0;
    else begin
      for (int i = 0; i < W; i++) begin
        case ({j[i], k[i]})
          2'b01:   q[i] <= 1'b0;
          2'b10:   q[i] <= 1'b1;
          2'b11:   q[i] <= ~q[i];
          default: q[i] <= q[i];
        endcase
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pmode: 0 no pause, 1 random pause, 2 pause held for 4 cycles mid-run.
  task automatic run_op(input int ld, input int tg, input bit d, input int pmode, input bit restart);
    int m, steps, paused, edges, held;
    bit p;
    bit finished;
    steps = d ? ((tg - ld) & MASK) : ((ld - tg) & MASK);
    load_val = ld[W-1:0];
    target   = tg[W-1:0];
    dir      = d;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    load_val = ~load_val;
    target   = ~target;
    dir      = ~d;
    check("load_busy", busy, 1);
    check("load_done", done, 0);
    tick();
    check("loaded_q", q, ld);
    m = ld; paused = 0; edges = 1; held = 0; finished = 0;
    for (int it = 0; it < 200 && !finished; it++) begin
      if (restart && it == 2) start = 1'b1;
      if (m == tg) begin
        pause = $urandom_range(0, 1);
        tick();
        start = 1'b0;
        edges++;
        check("done_pulse", done, 1);
        check("done_cycle", edges, steps + paused + 2);
        check("final_q", q, tg);
        finished = 1;
      end else begin
        p = 1'b0;
        if (pmode == 1) p = ($urandom_range(0, 2) == 0);
        if (pmode == 2 && it >= 2 && held < 4) begin p = 1'b1; held++; end
        pause = p;
        if (p) paused++;
        else m = d ? ((m + 1) & MASK) : ((m - 1) & MASK);
        tick();
        start = 1'b0;
        edges++;
        check("run_q", q, m);
        check("run_done", done, 0);
      end
    end
    pause = 1'b0;
    if (!finished) check("done_timeout", 0, 1);
    if (pmode == 2) check("pause_cycles", paused, 4);
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_q", q, tg);
  endtask

  task automatic run_to_nine(output bit ok);
    ok = 0;
    load_val = 4'd2; target = 4'd12; dir = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (q == 4'd9 && busy) ok = 1;
      else tick();
    end
    if (!ok) check("reach_nine", 0, 1);
  endtask

  initial begin
    bit ok;
    int ld, tg;
    bit d;
    repeat (2) tick();
    check("ff_reset_hi", ff_reset, 1);
    reset = 1'b0;
    #1;
    check("ff_reset_lo", ff_reset, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_jk", {j, k}, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_q", q, 0);
    end

    run_op(3, 7, 1'b1, 0, 1'b0);
    run_op(14, 1, 1'b1, 0, 1'b0);
    run_op(2, 13, 1'b0, 0, 1'b1);
    run_op(5, 5, 1'b1, 0, 1'b0);
    run_op(0, 8, 1'b1, 2, 1'b0);

    for (int n = 0; n < 20; n++) begin
      ld = $urandom_range(0, MASK);
      tg = $urandom_range(0, MASK);
      d  = $urandom_range(0, 1);
      run_op(ld, tg, d, 1, ($urandom_range(0, 3) == 0));
    end

    run_to_nine(ok);
    if (ok) begin
      reset = 1'b1;
      #1;
      check("mid_ff_reset", ff_reset, 1);
      tick();
      reset = 1'b0;
      check("rst_q", q, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_jk", {j, k}, 0);
      for (int i = 0; i < 6; i++) begin
        tick();
        check("rst_no_done", done, 0);
        check("rst_q_hold", q, 0);
      end
    end

`ifdef JK_SEQ_ABORT_EN
    run_to_nine(ok);
    if (ok) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_q", q, 9);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      for (int i = 0; i < 4; i++) begin
        tick();
        check("abort_no_done", done, 0);
        check("abort_q_hold", q, 9);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
